button_selector: RTL
====================

// Module: button_selector
//
// PURPOSE
// - Input-side counterpart of the LED mode output: reads two raw push-buttons and produces the 2-bit mode select.
// - Synchronises, debounces and edge-detects both buttons; NEXT steps sel up, PREV steps it down, wrap-around mod 4.
// - Auto-repeats while one button is held.
// - Sits between board pins and the sel input of the LED driver.
//
// PARAMETERS
// DEBOUNCE_BITS  20     debounce counter width; stable change needs 2**DEBOUNCE_BITS consecutive differing cycles
// REPEAT_BITS    24     auto-repeat counter width; repeat period 2**REPEAT_BITS cycles
// ACTIVE_LOW     1      1: raw button reads 0 when pressed; 0: reads 1 when pressed
// SEL_INIT       2'b00  sel value after reset
//
// PORTS
// clock        in   1  single system clock, all logic on posedge
// reset_n      in   1  asynchronous, active-low reset
// btn_raw      in   2  raw pins, asynchronous; [0]=NEXT, [1]=PREV
// btn_state    out  2  debounced pressed state, 1=pressed, registered
// sel          out  2  current mode select, registered
// sel_changed  out  1  one-cycle pulse, high in the same cycle sel takes its new value
//
// BEHAVIOUR
// - Reset (async, reset_n=0):
//   - sync flops = not-pressed; btn_state=2'b00; debounce and repeat counters=0.
//   - sel=SEL_INIT; sel_changed=0.
//   - Reset mid-press: after release of reset the button must re-debounce from not-pressed.
// - Sync: 2-flop synchroniser per bit, polarity normalised to 1=pressed after the second flop.
// - Debounce, per bit:
//   - synced==btn_state: counter <= 0.
//   - otherwise counter <= counter+1.
//   - When counter==all-ones and synced still differs: btn_state <= synced, counter <= 0.
//   - A single glitch cycle restarts the count.
//   - Latency raw->btn_state = 2 + 2**DEBOUNCE_BITS cycles.
// - Press event per bit = btn_state 0->1 (registered compare with previous btn_state). Release produces no event.
// - Auto-repeat, only while exactly one button is pressed:
//   - rpt_cnt counts every cycle from the press event.
//   - On wrap all-ones->0, a repeat event is issued for that button.
//   - rpt_cnt is cleared on any press event, when both buttons are pressed, or when none is pressed.
// - sel update, in the cycle after the event:
//   - NEXT event only: sel <= sel+1, so 3->0.
//   - PREV event only: sel <= sel-1, so 0->3.
//   - NEXT and PREV in the same cycle, or no event: sel holds and sel_changed=0.
//   - sel_changed=1 exactly when sel is written; every write changes the value.
// - Latency press event -> sel/sel_changed: 1 cycle. sel never changes more than once per cycle.
// - Width rule: all counters are unsigned, and no saturation beyond what is stated.
//
// STRUCTURE
// - Shared package: mode encodings SEL_SHOW=2'b00, SEL_INVERT=2'b01, SEL_OFF=2'b10, SEL_ON=2'b11.
//   The LED driver uses the same package; SEL_INIT defaults to SEL_SHOW.
// - One sub-module, button_debounce (params DEBOUNCE_BITS, ACTIVE_LOW):
//   - ports clock, reset_n, raw, state, press.
//   - instantiated twice.
// - Top level holds the repeat counter and the sel register.
//
// TESTING (bench uses DEBOUNCE_BITS=3, REPEAT_BITS=5, ACTIVE_LOW=1)
// 1. Reset with btn_raw=2'b11 -> btn_state=00, sel=00, sel_changed=0; hold 100 cycles, no change.
// 2. btn_raw[0]=0 held -> btn_state[0]=1 exactly 10 cycles later; sel=01 and one sel_changed pulse 1 cycle after that.
// 3. Press shorter than debounce:
//    - btn_raw[0]=0 for 7 cycles, 1 cycle high, 7 cycles low -> no btn_state change and no sel change.
//    - Continued low from then -> sel change as in 2.
// 4. Wrap and repeat:
//    - From sel=11, one NEXT press -> sel=00.
//    - From sel=00, one PREV press -> sel=11.
//    - PREV held 100 cycles after debounce -> 3 repeats at +32, +64, +96 cycles: sel 11->10->01->00->11.
// 5. Both buttons debounced in the same cycle -> sel unchanged, no pulse, no repeats while both are held.
//    - Release NEXT -> repeat timing restarts for PREV only.
// 6. Assert reset_n=0 asynchronously mid-repeat with sel=10 -> sel=00 immediately without a clock.
//    - Release reset while still pressed -> fresh press after 10 cycles, sel=01.

Source files
------------

// File: rtl/button_selector_pkg.sv
// Shared definitions for the push-button mode selector and the LED driver it feeds.
// Mode encodings, button indices and the wrap-around mode step live here.
package button_selector_pkg;

    typedef enum logic [1:0] {
        SEL_SHOW   = 2'b00,
        SEL_INVERT = 2'b01,
        SEL_OFF    = 2'b10,
        SEL_ON     = 2'b11
    } sel_mode_e;

    localparam int SEL_W    = 2;
    localparam int N_BTN    = 2;
    localparam int BTN_NEXT = 0;
    localparam int BTN_PREV = 1;

    // One mode step; the select is 2 bits wide, so 3+1 -> 0 and 0-1 -> 3.
    function automatic logic [SEL_W-1:0] sel_step(input logic [SEL_W-1:0] cur,
                                                   input logic             up);
        return up ? cur + SEL_W'(1) : cur - SEL_W'(1);
    endfunction

endpackage

// File: rtl/button_selector_if.sv
// Board-side bundle of the mode selector: raw pins in, debounced state and mode select out.
// Handshake: none; sel_changed is a one-cycle strobe, high in the cycle sel carries its new value.
interface button_selector_if;
    import button_selector_pkg::*;

    logic [N_BTN-1:0] btn_raw;
    logic [N_BTN-1:0] btn_state;
    logic [SEL_W-1:0] sel;
    logic             sel_changed;

    modport master (
        output btn_raw,
        input  btn_state,
        input  sel,
        input  sel_changed
    );

    modport slave (
        input  btn_raw,
        output btn_state,
        output sel,
        output sel_changed
    );

endinterface

// File: rtl/button_selector_debounce.sv
// One push-button channel: two-flop synchroniser, counter debounce, press (0->1) detect.
// The state only flips after 2**DEBOUNCE_BITS consecutive cycles of disagreement.
module button_debounce #(
    parameter int DEBOUNCE_BITS = 20,
    parameter bit ACTIVE_LOW    = 1'b1
) (
    input  logic clock,
    input  logic reset_n,
    input  logic raw,
    output logic state,
    output logic press
);

    // Raw level of a released button; the synchroniser resets to it so a reset
    // mid-press forces a fresh debounce.
    localparam logic IDLE_LEVEL = ACTIVE_LOW;

    logic                     r_sync1;
    logic                     r_sync2;
    logic                     r_state;
    logic                     r_prev_state;
    logic [DEBOUNCE_BITS-1:0] r_cnt;

    logic w_synced;
    logic w_differs;

    assign w_synced  = r_sync2 ^ IDLE_LEVEL;
    assign w_differs = (w_synced != r_state);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_sync1      <= IDLE_LEVEL;
            r_sync2      <= IDLE_LEVEL;
            r_state      <= 1'b0;
            r_prev_state <= 1'b0;
            r_cnt        <= '0;
        end else begin
            r_sync1      <= raw;
            r_sync2      <= r_sync1;
            r_prev_state <= r_state;
            if (!w_differs) begin
                r_cnt <= '0;
            end else if (&r_cnt) begin
                r_state <= w_synced;
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + DEBOUNCE_BITS'(1);
            end
        end
    end

    assign state = r_state;
    assign press = r_state & ~r_prev_state;

endmodule

// File: rtl/button_selector.sv
// Two-button mode selector: NEXT steps sel up, PREV steps it down, with auto-repeat
// while exactly one button is held.
module button_selector
    import button_selector_pkg::*;
#(
    parameter int               DEBOUNCE_BITS = 20,
    parameter int               REPEAT_BITS   = 24,
    parameter bit               ACTIVE_LOW    = 1'b1,
    parameter logic [SEL_W-1:0] SEL_INIT      = SEL_SHOW
) (
    input logic               clock,
    input logic               reset_n,
    button_selector_if.slave  bus
);

    logic [N_BTN-1:0] w_state;
    logic [N_BTN-1:0] w_press;

    button_debounce #(
        .DEBOUNCE_BITS (DEBOUNCE_BITS),
        .ACTIVE_LOW    (ACTIVE_LOW)
    ) u_next (
        .clock   (clock),
        .reset_n (reset_n),
        .raw     (bus.btn_raw[BTN_NEXT]),
        .state   (w_state[BTN_NEXT]),
        .press   (w_press[BTN_NEXT])
    );

    button_debounce #(
        .DEBOUNCE_BITS (DEBOUNCE_BITS),
        .ACTIVE_LOW    (ACTIVE_LOW)
    ) u_prev (
        .clock   (clock),
        .reset_n (reset_n),
        .raw     (bus.btn_raw[BTN_PREV]),
        .state   (w_state[BTN_PREV]),
        .press   (w_press[BTN_PREV])
    );

    logic [REPEAT_BITS-1:0] r_rpt_cnt;
    logic [SEL_W-1:0]       r_sel;
    logic                   r_sel_changed;

    logic                   w_one_pressed;
    logic                   w_rpt_run;
    logic                   w_rpt_wrap;
    logic                   w_evt_next;
    logic                   w_evt_prev;
    logic [REPEAT_BITS-1:0] w_rpt_cnt_nxt;
    logic [SEL_W-1:0]       w_sel_nxt;
    logic                   w_sel_changed_nxt;

    // The repeat counter only runs while a single button is held and no fresh
    // press is arriving; a fresh press restarts the repeat period from zero.
    assign w_one_pressed = w_state[BTN_NEXT] ^ w_state[BTN_PREV];
    assign w_rpt_run     = w_one_pressed && (w_press == '0);
    assign w_rpt_wrap    = w_rpt_run && (&r_rpt_cnt);
    assign w_evt_next    = w_press[BTN_NEXT] | (w_rpt_wrap & w_state[BTN_NEXT]);
    assign w_evt_prev    = w_press[BTN_PREV] | (w_rpt_wrap & w_state[BTN_PREV]);

    always_comb begin
        w_rpt_cnt_nxt     = '0;
        w_sel_nxt         = r_sel;
        w_sel_changed_nxt = 1'b0;

        if (w_rpt_run) begin
            w_rpt_cnt_nxt = r_rpt_cnt + REPEAT_BITS'(1);
        end

        // Simultaneous NEXT and PREV cancel out.
        unique case ({w_evt_prev, w_evt_next})
            2'b01: begin
                w_sel_nxt         = sel_step(r_sel, 1'b1);
                w_sel_changed_nxt = 1'b1;
            end
            2'b10: begin
                w_sel_nxt         = sel_step(r_sel, 1'b0);
                w_sel_changed_nxt = 1'b1;
            end
            default: begin
                w_sel_nxt         = r_sel;
                w_sel_changed_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_rpt_cnt     <= '0;
            r_sel         <= SEL_INIT;
            r_sel_changed <= 1'b0;
        end else begin
            r_rpt_cnt     <= w_rpt_cnt_nxt;
            r_sel         <= w_sel_nxt;
            r_sel_changed <= w_sel_changed_nxt;
        end
    end

    assign bus.btn_state   = w_state;
    assign bus.sel         = r_sel;
    assign bus.sel_changed = r_sel_changed;

endmodule
